overlay_ctrl: RTL and testbench

//  Sequencer for one overlay job: streams a program into the PE array, feeds PE_NUM operand words into the input SIPO, waits a programmed compute time, pulses the output PISO load, then drains results.

---
 rtl/overlay_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_overlay_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/overlay_ctrl.sv
// overlay_ctrl
//   Sequencer for one overlay job. It streams a program into the PE array,
//   feeds PE_NUM operand words into the input SIPO, and waits a programmed
//   number of compute cycles. It then pulses the output PISO load and counts
//   the serial result words coming back. Only one job is in flight at a time.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   start           begin a job (sampled only in IDLE)
//   cfg_inst_num    instructions to stream this job (latched at start)
//   cfg_comp_cyc    compute wait after the last operand (latched at start)
//   busy, done      host handshake: busy for the whole job, done pulses on
//                   the last result word
//   inst_s_*        host instruction stream (valid/ready)
//   data_s_*        host operand stream (valid/ready)
//   inst_in_v/inst_in         registered instruction towards the overlay
//   din_overlay_v/din_overlay registered operand towards the overlay
//   load            PISO parallel-load strobe
//   dout_overlay_v  serial result valid from the overlay
//
// Handshake: a word moves when valid and ready are both high in the same
// cycle. Ready depends only on the registered state, so a valid never
// feeds combinationally into a ready. A valid held while ready is low
// stays pending until ready rises.
module overlay_ctrl #(
  parameter int PE_NUM     = 8,
  parameter int DATA_WIDTH = 16,
  parameter int INST_WIDTH = 64,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              cfg_inst_num,
  input  logic [CNT_W-1:0]        cfg_comp_cyc,
  output logic                    busy,
  output logic                    done,
  input  logic                    inst_s_valid,
  input  logic [INST_WIDTH-1:0]   inst_s_data,
  output logic                    inst_s_ready,
  input  logic                    data_s_valid,
  input  logic [DATA_WIDTH*2-1:0] data_s_data,
  output logic                    data_s_ready,
  output logic                    inst_in_v,
  output logic [INST_WIDTH-1:0]   inst_in,
  output logic                    din_overlay_v,
  output logic [DATA_WIDTH*2-1:0] din_overlay,
  output logic                    load,
  input  logic                    dout_overlay_v
);

  localparam int PW = $clog2(PE_NUM + 1);
  localparam logic [PW-1:0] PE_LAST = PW'(PE_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INST,
    S_DATA,
    S_COMP,
    S_LOAD,
    S_DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [7:0]       inst_num_q;
  logic [7:0]       inst_cnt;
  logic [CNT_W-1:0] comp_cyc_q;
  logic [CNT_W-1:0] comp_cnt;
  logic [PW-1:0]    data_cnt;
  logic [PW-1:0]    drain_cnt;

  logic inst_xfer;
  logic data_xfer;
  logic job_start;

  assign inst_xfer = inst_s_valid & inst_s_ready;
  assign data_xfer = data_s_valid & data_s_ready;
  assign job_start = (state == S_IDLE) & start;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nxt    = state;
    busy         = (state != S_IDLE);
    done         = 1'b0;
    inst_s_ready = 1'b0;
    data_s_ready = 1'b0;
    load         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (cfg_inst_num != 8'd0) ? S_INST : S_DATA;
        end
      end
      S_INST: begin
        inst_s_ready = 1'b1;
        if (inst_s_valid && (inst_cnt == inst_num_q - 8'd1)) begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        data_s_ready = 1'b1;
        if (data_s_valid && (data_cnt == PE_LAST)) begin
          state_nxt = S_COMP;
        end
      end
      S_COMP: begin
        // comp_cnt starts at 0 on entry, so cfg_comp_cyc=N spends N+1 cycles here
        if (comp_cnt == comp_cyc_q) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        load      = 1'b1;
        state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // done follows the last result valid in the same cycle
        if (dout_overlay_v && (drain_cnt == PE_LAST)) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Configuration, counters and registered overlay-side data
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_num_q    <= '0;
      comp_cyc_q    <= '0;
      inst_cnt      <= '0;
      comp_cnt      <= '0;
      data_cnt      <= '0;
      drain_cnt     <= '0;
      inst_in_v     <= 1'b0;
      inst_in       <= '0;
      din_overlay_v <= 1'b0;
      din_overlay   <= '0;
    end else begin
      inst_in_v     <= inst_xfer;
      din_overlay_v <= data_xfer;
      // Data outputs hold their last value when no transfer happens
      if (inst_xfer) begin
        inst_in <= inst_s_data;
      end
      if (data_xfer) begin
        din_overlay <= data_s_data;
      end

      if (job_start) begin
        inst_num_q <= cfg_inst_num;
        comp_cyc_q <= cfg_comp_cyc;
        inst_cnt   <= '0;
        comp_cnt   <= '0;
        data_cnt   <= '0;
        drain_cnt  <= '0;
      end else begin
        if (inst_xfer) begin
          inst_cnt <= inst_cnt + 8'd1;
        end
        if (data_xfer) begin
          data_cnt <= data_cnt + 1'b1;
        end
        if (state == S_COMP) begin
          comp_cnt <= comp_cnt + 1'b1;
        end
        // Result valids outside DRAIN are ignored
        if ((state == S_DRAIN) && dout_overlay_v) begin
          drain_cnt <= drain_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_overlay_ctrl.sv
// tb_overlay_ctrl
//   Job-level bench for overlay_ctrl. A table of job records (configuration
//   plus expected load latency) is applied in a loop, followed by randomized
//   jobs whose expectations come from the job-level timing rule. Words sent
//   to the host streams are pushed into expected queues and popped when the
//   overlay-side valids appear.
module tb_overlay_ctrl;

  localparam int PE_NUM = 8;
  localparam int DW     = 16;
  localparam int IW     = 64;
  localparam int CW     = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [7:0]    cfg_inst_num;
  logic [CW-1:0] cfg_comp_cyc;
  logic          busy;
  logic          done;
  logic          inst_s_valid;
  logic [IW-1:0] inst_s_data;
  logic          inst_s_ready;
  logic          data_s_valid;
  logic [2*DW-1:0] data_s_data;
  logic          data_s_ready;
  logic          inst_in_v;
  logic [IW-1:0] inst_in;
  logic          din_overlay_v;
  logic [2*DW-1:0] din_overlay;
  logic          load;
  logic          dout_overlay_v;

  overlay_ctrl #(
    .PE_NUM(PE_NUM), .DATA_WIDTH(DW), .INST_WIDTH(IW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_inst_num(cfg_inst_num), .cfg_comp_cyc(cfg_comp_cyc),
    .busy(busy), .done(done),
    .inst_s_valid(inst_s_valid), .inst_s_data(inst_s_data), .inst_s_ready(inst_s_ready),
    .data_s_valid(data_s_valid), .data_s_data(data_s_data), .data_s_ready(data_s_ready),
    .inst_in_v(inst_in_v), .inst_in(inst_in),
    .din_overlay_v(din_overlay_v), .din_overlay(din_overlay),
    .load(load), .dout_overlay_v(dout_overlay_v)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int load_pulses = 0;
  logic [IW-1:0]   exp_inst_q[$];
  logic [2*DW-1:0] exp_data_q[$];

  typedef struct {
    int inst_num;
    int comp_cyc;
    int gap_pct;
    bit spurious;
    bit start_in_drain;
    int exp_load_dly;
  } job_t;

  job_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare overlay-side outputs against the expected queues
  task automatic monitor();
    if (inst_in_v) begin
      if (exp_inst_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL inst_unexpected actual=%0h expected=none", inst_in);
      end else begin
        check("inst_word", inst_in, exp_inst_q.pop_front());
      end
    end
    if (din_overlay_v) begin
      if (exp_data_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL data_unexpected actual=%0h expected=none", din_overlay);
      end else begin
        check("data_word", 64'(din_overlay), 64'(exp_data_q.pop_front()));
      end
    end
    if (load) load_pulses++;
  endtask

  // Advance one cycle; sample at the following falling edge
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic idle_inputs();
    start          = 1'b0;
    inst_s_valid   = 1'b0;
    data_s_valid   = 1'b0;
    dout_overlay_v = 1'b0;
  endtask

  task automatic reset_and_check(input int n);
    idle_inputs();
    rst = 1'b1;
    repeat (n) step();
    exp_inst_q.delete();
    exp_data_q.delete();
    check("rst_busy",    busy, 0);
    check("rst_done",    done, 0);
    check("rst_ready",   {inst_s_ready, data_s_ready}, 0);
    check("rst_valids",  {inst_in_v, din_overlay_v, load}, 0);
    check("rst_inst_in", inst_in, 0);
    check("rst_din",     64'(din_overlay), 0);
    rst = 1'b0;
  endtask

  task automatic run_job(input job_t j);
    int sent;
    int guard;
    int last_xfer;
    bit v;
    logic [IW-1:0]   iw;
    logic [2*DW-1:0] dw;
    logic [2*DW-1:0] last_word;
    last_xfer = 0;
    last_word = '0;
    load_pulses = 0;
    check("idle_busy", busy, 0);
    cfg_inst_num = 8'(j.inst_num);
    cfg_comp_cyc = CW'(j.comp_cyc);
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_inst_num = 8'($urandom);
    cfg_comp_cyc = CW'($urandom);
    check("busy_after_start", busy, 1);

    // Instruction phase
    sent = 0;
    guard = 0;
    while (sent < j.inst_num && guard < 2000) begin
      check("inst_phase_ready", {inst_s_ready, data_s_ready}, 2'b10);
      iw = {$urandom, $urandom};
      v = ($urandom_range(99) >= j.gap_pct);
      inst_s_valid = v;
      inst_s_data  = iw;
      if (v && inst_s_ready) begin
        exp_inst_q.push_back(iw);
        sent++;
      end
      step();
      guard++;
    end
    inst_s_valid = 1'b0;
    check("inst_phase_timeout", guard < 2000, 1);

    // Operand phase
    sent = 0;
    guard = 0;
    while (sent < PE_NUM && guard < 2000) begin
      check("data_phase_ready", {inst_s_ready, data_s_ready}, 2'b01);
      dw = $urandom;
      v = ($urandom_range(99) >= j.gap_pct);
      data_s_valid = v;
      data_s_data  = dw;
      if (v && data_s_ready) begin
        exp_data_q.push_back(dw);
        last_word = dw;
        last_xfer = cyc;
        sent++;
      end
      step();
      guard++;
    end
    data_s_valid = 1'b0;
    data_s_data  = $urandom;
    check("data_phase_timeout", guard < 2000, 1);

    // Compute wait, optionally with spurious result valids
    guard = 0;
    while (!load && guard < 200) begin
      check("comp_ready", {inst_s_ready, data_s_ready}, 0);
      dout_overlay_v = j.spurious ? 1'($urandom_range(1)) : 1'b0;
      step();
      guard++;
    end
    dout_overlay_v = 1'b0;
    check("load_timeout", guard < 200, 1);
    check("load_delay", cyc - last_xfer, j.exp_load_dly);
    check("din_hold", 64'(din_overlay), 64'(last_word));
    check("queues_drained", exp_inst_q.size() + exp_data_q.size(), 0);
    step();

    // Drain phase: done must follow the PE_NUM-th result valid
    sent = 0;
    guard = 0;
    while (sent < PE_NUM && guard < 2000) begin
      v = ($urandom_range(99) >= j.gap_pct);
      dout_overlay_v = v;
      if (j.start_in_drain) start = (v && sent == PE_NUM - 1) ? 1'b1 : 1'($urandom_range(1));
      #1;
      check("done", done, (v && sent == PE_NUM - 1) ? 1 : 0);
      check("drain_busy", busy, 1);
      if (v) sent++;
      step();
      guard++;
    end
    dout_overlay_v = 1'b0;
    check("drain_timeout", guard < 2000, 1);
    // A start held through the done cycle must not have been taken
    check("post_done_busy", busy, 0);
    check("post_done_done", done, 0);
    start = 1'b0;
    check("load_pulses", load_pulses, 1);
  endtask

  initial begin
    job_t j;
    logic [2*DW-1:0] w;
    idle_inputs();
    rst = 1'b1;
    cfg_inst_num = '0;
    cfg_comp_cyc = '0;
    inst_s_data  = '0;
    data_s_data  = '0;
    @(negedge clk);
    reset_and_check(3);

    // Reset in the middle of the operand phase aborts the job
    cfg_inst_num = 8'd0;
    cfg_comp_cyc = 16'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t1_data_ready", data_s_ready, 1);
      w = $urandom;
      data_s_valid = 1'b1;
      data_s_data  = w;
      exp_data_q.push_back(w);
      step();
    end
    reset_and_check(3);

    //               inst comp gap spur sidr load_dly
    tbl[0] = '{4,   10,  0,  1'b0, 1'b0, 12};
    tbl[1] = '{0,   0,   0,  1'b0, 1'b0, 2};
    tbl[2] = '{6,   3,   50, 1'b0, 1'b0, 5};
    tbl[3] = '{2,   1,   40, 1'b0, 1'b1, 3};
    tbl[4] = '{1,   5,   0,  1'b1, 1'b0, 7};
    tbl[5] = '{20,  0,   30, 1'b1, 1'b1, 2};
    for (int i = 0; i < 6; i++) begin
      run_job(tbl[i]);
      step();
    end

    // Randomized jobs: compute wait of N gives N+1 compute cycles, then load
    for (int i = 0; i < 8; i++) begin
      j.inst_num       = $urandom_range(0, 12);
      j.comp_cyc       = $urandom_range(0, 20);
      j.gap_pct        = $urandom_range(0, 50);
      j.spurious       = 1'($urandom_range(1));
      j.start_in_drain = 1'($urandom_range(1));
      j.exp_load_dly   = j.comp_cyc + 2;
      run_job(j);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
